// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the muldiv_seq multiply/divide sequencer.
package muldiv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE,
        ST_KILL
    } state_t;

    // Bit positions inside the one-hot req_op vector.
    localparam int OP_MUL_LO = 0;
    localparam int OP_REM    = 1;
    localparam int OP_MUL_HI = 2;
    localparam int OP_QUO    = 3;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/muldiv_wdog.sv
// Watchdog counter: expired is high on the (2^WDOG_W)-1'th consecutive enabled cycle.
module muldiv_wdog
    import muldiv_seq_pkg::*;
#(
    parameter int WDOG_W = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LAST = {{(WDOG_W-1){1'b1}}, 1'b0};
    localparam logic [WDOG_W-1:0] ONE  = {{(WDOG_W-1){1'b0}}, 1'b1};

    logic [WDOG_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + ONE;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/muldiv_seq.sv
// Multiply/divide sequencer between the EX stage and external mul/div units.
// Optional macro DIV_ZERO_FAST_EN: divide by zero completes without the divider.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WDOG_W = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic        req_sign,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mul_in_valid,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    output logic [1:0]  mul_sign,
    input  logic        mul_out_valid,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    output logic        div_in_valid,
    output logic        div_signed,
    output logic [31:0] div_src1,
    output logic [31:0] div_src2,
    input  logic        div_out_valid,
    input  logic [31:0] quotient,
    input  logic [31:0] remainder,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic        sign_q;
    logic [31:0] src1_q, src2_q;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;
    logic        fire;
    logic        is_mul_q;
    logic        unit_done;
    logic [31:0] unit_word;
    logic        wdog_clear, wdog_en, wdog_expired;

    assign fire      = req_valid & req_ready & ~flush;
    assign is_mul_q  = op_q[OP_MUL_LO] | op_q[OP_MUL_HI];
    assign unit_done = is_mul_q ? mul_out_valid : div_out_valid;

    // The latched op is one-hot here, so masking selects exactly one word.
    assign unit_word = ({32{op_q[OP_MUL_LO]}} & mul_lo)
                     | ({32{op_q[OP_MUL_HI]}} & mul_hi)
                     | ({32{op_q[OP_REM]}}    & remainder)
                     | ({32{op_q[OP_QUO]}}    & quotient);

    // NOTE: every always_comb output gets a default first; a missed branch would
    // otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    if (!is_onehot4(req_op)) begin
                        state_d  = ST_DONE;
                        result_d = '0;
                        err_d    = 1'b1;
                    end else if (req_op[OP_MUL_LO] | req_op[OP_MUL_HI]) begin
                        state_d = ST_MUL;
`ifdef DIV_ZERO_FAST_EN
                    end else if (req_src2 == '0) begin
                        state_d  = ST_DONE;
                        result_d = ({32{req_op[OP_QUO]}} & DIV_ZERO_QUOT)
                                 | ({32{req_op[OP_REM]}} & req_src1);
                        err_d    = 1'b0;
`endif
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (flush && unit_done) begin
                    state_d = ST_IDLE;
                end else if (flush) begin
                    state_d = ST_KILL;
                end else if (unit_done) begin
                    state_d  = ST_DONE;
                    result_d = unit_word;
                    err_d    = 1'b0;
                end else if (wdog_expired) begin
                    state_d  = ST_DONE;
                    result_d = '0;
                    err_d    = 1'b1;
                end
            end
            ST_DONE: begin
                if (flush || resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_KILL: begin
                if (unit_done || wdog_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the operand latches are reset along with the control state so the
    // unit-facing operand ports never show X after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            sign_q   <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            err_q    <= err_d;
            if (fire) begin
                op_q   <= req_op;
                sign_q <= req_sign;
                src1_q <= req_src1;
                src2_q <= req_src2;
            end
        end
    end

    assign wdog_en    = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_KILL);
    assign wdog_clear = (state_d != state_q);

    muldiv_wdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wdog_clear),
        .enable  (wdog_en),
        .expired (wdog_expired)
    );

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    // A flush in DONE drops the response, so it must not look like a handshake.
    assign resp_valid   = (state_q == ST_DONE) & ~flush;
    assign resp_data    = result_q;
    assign resp_err     = (state_q == ST_DONE) & err_q;

    assign mul_in_valid = (state_q == ST_MUL);
    assign mul_src1     = src1_q;
    assign mul_src2     = src2_q;
    assign mul_sign     = {~sign_q, ~sign_q};

    assign div_in_valid = (state_q == ST_DIV);
    assign div_signed   = sign_q;
    assign div_src1     = src1_q;
    assign div_src2     = src2_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: scoreboard plus arithmetic reference model.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_sign, flush;
    logic [3:0]  req_op;
    logic [31:0] req_src1, req_src2;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_data;
    logic        mul_in_valid, mul_out_valid;
    logic [31:0] mul_src1, mul_src2, mul_hi, mul_lo;
    logic [1:0]  mul_sign;
    logic        div_in_valid, div_signed, div_out_valid;
    logic [31:0] div_src1, div_src2, quotient, remainder;
    logic        busy;

    always #5 clk = ~clk;

    muldiv_seq #(.WDOG_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_sign(req_sign),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .mul_in_valid(mul_in_valid), .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_sign(mul_sign),
        .mul_out_valid(mul_out_valid), .mul_hi(mul_hi), .mul_lo(mul_lo),
        .div_in_valid(div_in_valid), .div_signed(div_signed), .div_src1(div_src1), .div_src2(div_src2),
        .div_out_valid(div_out_valid), .quotient(quotient), .remainder(remainder),
        .busy(busy)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   fire_cyc = 0;
    int   mul_lat  = 3;     // cycles from fire to unit answer; 0 = never answers
    int   div_lat  = 3;
    int   ready_mode = 0;   // 0 always ready, 1 random, 2 held low

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input logic sg);
        longint sa, sb;
        longint unsigned ua, ub;
        if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        ua = 64'(a);
        ub = 64'(b);
        return ua * ub;
    endfunction

    // Returns {quotient, remainder} with the usual RISC-V corner cases.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b, input logic sg);
        int sa, sb;
        if (b == 32'h0) return {32'hFFFF_FFFF, a};
        if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'h0};
            sa = a;
            sb = b;
            return {32'(sa / sb), 32'(sa % sb)};
        end
        return {a / b, a % b};
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p, qr;
        e.data = '0;
        e.err  = 1'b0;
        p  = mul64(a, b, sg);
        qr = div64(a, b, sg);
        case (op)
            4'b0001: e.data = p[31:0];
            4'b0100: e.data = p[63:32];
            4'b0010: e.data = qr[31:0];
            4'b1000: e.data = qr[63:32];
            default: e.err  = 1'b1;
        endcase
        return e;
    endfunction

    initial begin : mul_unit
        int          cnt;
        bit          pend;
        logic [63:0] p;
        cnt = 0; pend = 0;
        mul_out_valid = 1'b0; mul_hi = '0; mul_lo = '0;
        forever begin
            @(negedge clk);
            if (mul_out_valid) begin
                mul_out_valid = 1'b0;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin mul_out_valid = 1'b1; pend = 0; end
            end else if (mul_in_valid && mul_lat != 0) begin
                p = mul64(mul_src1, mul_src2, ~mul_sign[0]);
                {mul_hi, mul_lo} = p;
                cnt = mul_lat - 1;
                if (cnt == 0) mul_out_valid = 1'b1; else pend = 1;
            end
        end
    end

    initial begin : div_unit
        int          cnt;
        bit          pend;
        logic [63:0] qr;
        cnt = 0; pend = 0;
        div_out_valid = 1'b0; quotient = '0; remainder = '0;
        forever begin
            @(negedge clk);
            if (div_out_valid) begin
                div_out_valid = 1'b0;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin div_out_valid = 1'b1; pend = 0; end
            end else if (div_in_valid && div_lat != 0) begin
                qr = div64(div_src1, div_src2, div_signed);
                {quotient, remainder} = qr;
                cnt = div_lat - 1;
                if (cnt == 0) div_out_valid = 1'b1; else pend = 1;
            end
        end
    end

    initial begin : sink
        resp_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                1:       resp_ready = ($urandom_range(0, 3) != 0);
                2:       resp_ready = 1'b0;
                default: resp_ready = 1'b1;
            endcase
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && resp_valid && resp_ready) begin
                check("resp_expected", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("resp_data", resp_data, e.data);
                    check("resp_err", resp_err, e.err);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input bit push);
        int w = 0;
        while (!req_ready && w < 100) begin @(negedge clk); w++; end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_sign = sg; req_src1 = a; req_src2 = b;
        fire_cyc = cyc;
        if (push) sb_q.push_back(model(op, sg, a, b));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit saw_mul, output bit saw_div);
        int w = 0;
        saw_mul = 0; saw_div = 0;
        forever begin
            saw_mul |= mul_in_valid;
            saw_div |= div_in_valid;
            if (resp_valid || w >= 100) break;
            @(negedge clk);
            w++;
        end
        lat = cyc - fire_cyc;
    endtask

    task automatic drain();
        int w = 0;
        while ((sb_q.size() != 0 || !req_ready) && w < 500) begin @(negedge clk); w++; end
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin : stim
        int       lat;
        bit       saw_mul, saw_div, saw_resp, saw_busy;
        logic [3:0]  op;
        logic [31:0] a, b;
        int       r;

        reset = 1'b1; req_valid = 1'b0; flush = 1'b0;
        req_op = '0; req_sign = 1'b0; req_src1 = '0; req_src2 = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mul_in_valid", mul_in_valid, 0);
        check("rst_div_in_valid", div_in_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_data", resp_data, 0);
        reset = 1'b0;
        @(negedge clk);

        // Signed 7 * -3, low word, unit answers 3 cycles after the fire.
        mul_lat = 3;
        issue(4'b0001, 1'b1, 32'd7, 32'hFFFF_FFFD, 1);
        check("mul_in_valid_up", mul_in_valid, 1);
        check("mul_sign_signed", mul_sign, 2'b00);
        check("mul_src2", mul_src2, 32'hFFFF_FFFD);
        wait_valid(lat, saw_mul, saw_div);
        check("mul_latency", lat, 4);
        check("mul_result", resp_data, 32'hFFFF_FFEB);
        drain();

        // Unsigned 100 % 7 through the divider only.
        div_lat = 4;
        issue(4'b0010, 1'b0, 32'd100, 32'd7, 1);
        check("div_signed_low", div_signed, 0);
        wait_valid(lat, saw_mul, saw_div);
        check("div_no_mul_in_valid", saw_mul, 0);
        check("div_in_valid_seen", saw_div, 1);
        check("rem_result", resp_data, 32'd2);
        drain();

        // Back-pressure in DONE.
        ready_mode = 2; mul_lat = 2;
        issue(4'b0001, 1'b0, 32'h1234, 32'h10, 1);
        wait_valid(lat, saw_mul, saw_div);
        for (int i = 0; i < 5; i++) begin
            check("hold_data", resp_data, 32'h12340);
            check("hold_req_ready", req_ready, 0);
            check("hold_valid", resp_valid, 1);
            @(negedge clk);
        end
        ready_mode = 0;
        drain();

        // Reset in MUL abandons the op; the late answer is ignored.
        mul_lat = 6;
        issue(4'b0001, 1'b0, 32'd5, 32'd6, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_resp_data", resp_data, 0);
        reset = 1'b0;
        saw_resp = 0; saw_busy = 0;
        while (cyc < fire_cyc + 10) begin
            saw_resp |= resp_valid; saw_busy |= busy;
            @(negedge clk);
        end
        check("rst_mid_no_resp", saw_resp, 0);
        check("rst_mid_stays_idle", saw_busy, 0);

        // Flush two cycles after a divide fire, unit answers 6 cycles later.
        div_lat = 8;
        issue(4'b1000, 1'b1, 32'd50, 32'd5, 0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("kill_div_in_valid", div_in_valid, 0);
        check("kill_busy", busy, 1);
        saw_resp = 0;
        while (cyc < fire_cyc + 9) begin
            saw_resp |= resp_valid;
            if (cyc == fire_cyc + 8) check("kill_busy_at_answer", busy, 1);
            @(negedge clk);
        end
        check("kill_idle_after_answer", req_ready, 1);
        check("kill_no_resp", saw_resp, 0);

        // Flush together with the unit answer goes straight to IDLE.
        mul_lat = 3;
        issue(4'b0100, 1'b1, 32'hDEAD_BEEF, 32'd3, 0);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_answer_idle", busy, 0);
        check("flush_answer_no_resp", resp_valid, 0);

        // Flush in IDLE blocks the fire.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b0001; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        check("flush_idle_blocks", busy, 0);

        // Flush in DONE drops the response.
        ready_mode = 2; mul_lat = 2;
        issue(4'b0001, 1'b0, 32'd3, 32'd4, 0);
        wait_valid(lat, saw_mul, saw_div);
        flush = 1'b1;
        #1;
        check("done_flush_no_valid", resp_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        check("done_flush_idle", busy, 0);
        ready_mode = 0;

        // Non-one-hot ops return an error without touching the units.
        issue(4'b0011, 1'b0, 32'd9, 32'd9, 1);
        wait_valid(lat, saw_mul, saw_div);
        check("bad_op_latency", lat, 1);
        check("bad_op_no_unit", saw_mul | saw_div, 0);
        drain();
        issue(4'b0000, 1'b1, 32'd1, 32'd2, 1);
        drain();

        // Divider never answers: watchdog limit 15 cycles in DIV.
        div_lat = 0;
        issue(4'b1000, 1'b0, 32'd9, 32'd3, 0);
        sb_q.push_back('{data: 32'h0, err: 1'b1});
        wait_valid(lat, saw_mul, saw_div);
        check("wdog_latency", lat, 16);
        check("wdog_err", resp_err, 1);
        drain();

        // Divide by zero.
        div_lat = 3;
        issue(4'b1000, 1'b0, 32'd5, 32'd0, 1);
        wait_valid(lat, saw_mul, saw_div);
`ifdef DIV_ZERO_FAST_EN
        check("dz_quo_latency", lat, 1);
        check("dz_quo_no_div_in_valid", saw_div, 0);
`else
        check("dz_quo_latency", lat, 4);
`endif
        check("dz_quo_data", resp_data, 32'hFFFF_FFFF);
        drain();
        issue(4'b0010, 1'b0, 32'd5, 32'd0, 1);
        wait_valid(lat, saw_mul, saw_div);
        check("dz_rem_data", resp_data, 32'd5);
        drain();

        // Randomized traffic with random unit latency and back-pressure.
        ready_mode = 1;
        for (int i = 0; i < 60; i++) begin
            mul_lat = $urandom_range(1, 8);
            div_lat = $urandom_range(1, 8);
            r = $urandom_range(0, 11);
            if (r == 0) begin
                op = 4'($urandom_range(0, 15));
                if ($countones(op) == 1) op = 4'b0110;
            end else begin
                op = 4'b0001 << $urandom_range(0, 3);
            end
            a = $urandom;
            b = (r < 3) ? 32'($urandom_range(0, 3)) : $urandom;
            if (r == 11) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            issue(op, 1'($urandom_range(0, 1)), a, b, 1);
        end
        drain();
        ready_mode = 0;

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
